reg_scoreboard: RTL and testbench



---
 rtl/reg_scoreboard.sv | 112 +++++++++++
 tb/tb_reg_scoreboard.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: per-register pending-write counters with a decode-stage stall.
// Optional macro SCOREBOARD_BYPASS_EN lets a same-cycle write-back clear the hazard it resolves.
module reg_scoreboard #(
  parameter int CNT_W = 2,
  parameter int NREG  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic            issue_wr,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      issue_rn,
  input  logic [4:0]      issue_rm,
  input  logic            issue_use_rm,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            stall,
  output logic [NREG-1:0] busy,
  output logic            underflow_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic             uf_q, uf_d;

  logic [CNT_W-1:0] cnt_rn_s, cnt_rm_s, cnt_rd_s, cnt_wb_s;
  logic             raw_n_s, raw_m_s, sat_s, stall_s;
  logic             accepted_s, retire_s;

  // X31 and any address at or beyond NREG-1 are never tracked
  function automatic logic tracked(input logic [4:0] addr);
    return int'(addr) < (NREG - 1);
  endfunction

  // One-hot decode of the four register addresses into counter reads
  always_comb begin
    cnt_rn_s = CNT_ZERO;
    cnt_rm_s = CNT_ZERO;
    cnt_rd_s = CNT_ZERO;
    cnt_wb_s = CNT_ZERO;
    for (int i = 0; i < NREG - 1; i++) begin
      cnt_rn_s = cnt_rn_s | (cnt_q[i] & {CNT_W{int'(issue_rn) == i}});
      cnt_rm_s = cnt_rm_s | (cnt_q[i] & {CNT_W{int'(issue_rm) == i}});
      cnt_rd_s = cnt_rd_s | (cnt_q[i] & {CNT_W{int'(issue_rd) == i}});
      cnt_wb_s = cnt_wb_s | (cnt_q[i] & {CNT_W{int'(wb_rd) == i}});
    end
  end

  // Hazard terms and the stall decision
  always_comb begin
    retire_s = wb_valid && tracked(wb_rd);
    raw_n_s  = tracked(issue_rn) && (cnt_rn_s != CNT_ZERO);
    raw_m_s  = issue_use_rm && tracked(issue_rm) && (cnt_rm_s != CNT_ZERO);
    sat_s    = issue_wr && tracked(issue_rd) && (cnt_rd_s == CNT_MAX);
`ifdef SCOREBOARD_BYPASS_EN
    // The last outstanding write retiring now satisfies the read this cycle
    raw_n_s  = raw_n_s && !(retire_s && (wb_rd == issue_rn) && (cnt_rn_s == CNT_ONE));
    raw_m_s  = raw_m_s && !(retire_s && (wb_rd == issue_rm) && (cnt_rm_s == CNT_ONE));
    sat_s    = sat_s && !(retire_s && (wb_rd == issue_rd));
`else
    raw_n_s  = raw_n_s;
    raw_m_s  = raw_m_s;
    sat_s    = sat_s;
`endif
    stall_s    = issue_valid && (raw_n_s || raw_m_s || sat_s);
    accepted_s = issue_valid && !stall_s && issue_wr && tracked(issue_rd);
  end

  // Next-state counters: a same-register issue and retire cancel out
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      if (accepted_s && (int'(issue_rd) == i) && retire_s && (int'(wb_rd) == i)) begin
        cnt_d[i] = cnt_q[i];
      end else if (accepted_s && (int'(issue_rd) == i)) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (retire_s && (int'(wb_rd) == i) && (cnt_q[i] != CNT_ZERO)) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      busy_d[i] = (cnt_d[i] != CNT_ZERO);
    end
    uf_d = uf_q || (retire_s && (cnt_wb_s == CNT_ZERO));
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      busy_q <= {NREG{1'b0}};
      uf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      busy_q <= busy_d;
      uf_q   <= uf_d;
    end
  end

  assign stall         = stall_s;
  assign busy          = busy_q;
  assign underflow_err = uf_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard; follows SCOREBOARD_BYPASS_EN when defined.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_wr, issue_use_rm, wb_valid;
  logic [4:0]  issue_rd, issue_rn, issue_rm, wb_rd;
  logic        stall, underflow_err;
  logic [31:0] busy;

  int checks   = 0;
  int failures = 0;

  reg_scoreboard #(.CNT_W(2), .NREG(32)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .issue_rn(issue_rn), .issue_rm(issue_rm), .issue_use_rm(issue_use_rm),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall), .busy(busy), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic wr, input logic [4:0] rd,
                       input logic [4:0] rn, input logic [4:0] rm, input logic use_rm,
                       input logic wbv, input logic [4:0] wbrd);
    issue_valid  = v;
    issue_wr     = wr;
    issue_rd     = rd;
    issue_rn     = rn;
    issue_rm     = rm;
    issue_use_rm = use_rm;
    wb_valid     = wbv;
    wb_rd        = wbrd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5);
    tick();
    tick();
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++;
    if (busy !== 32'h0) begin failures++; $display("FAIL reset_busy: got %h expected 00000000", busy); end
    checks++;
    if (underflow_err !== 1'b0) begin failures++; $display("FAIL reset_uf: got %b expected 0", underflow_err); end
    reset = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_issue();
    drive(1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL issue_stall: got %b expected 0", stall); end
    tick();
    idle();
    checks++;
    if (busy !== 32'h0000_0020) begin failures++; $display("FAIL issue_busy: got %h expected 00000020", busy); end
  endtask

  task automatic test_raw();
    drive(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL raw_rn: got %b expected 1", stall); end
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 5'd0);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL raw_rm: got %b expected 1", stall); end
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 5'd0);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL raw_rm_unused: got %b expected 0", stall); end
    drive(1'b0, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL raw_novalid: got %b expected 0", stall); end
    drive(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5);
    checks++;
`ifdef SCOREBOARD_BYPASS_EN
    if (stall !== 1'b0) begin failures++; $display("FAIL raw_wb_cycle: got %b expected 0", stall); end
`else
    if (stall !== 1'b1) begin failures++; $display("FAIL raw_wb_cycle: got %b expected 1", stall); end
`endif
    tick();
    drive(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL raw_after_wb: got %b expected 0", stall); end
    checks++;
    if (busy !== 32'h0) begin failures++; $display("FAIL raw_busy_clear: got %h expected 00000000", busy); end
    tick();
    idle();
  endtask

  task automatic test_x31();
    drive(1'b1, 1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 5'd31);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL x31_stall: got %b expected 0", stall); end
    tick();
    idle();
    checks++;
    if (busy !== 32'h0) begin failures++; $display("FAIL x31_busy: got %h expected 00000000", busy); end
    checks++;
    if (underflow_err !== 1'b0) begin failures++; $display("FAIL x31_uf: got %b expected 0", underflow_err); end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
      checks++;
      if (stall !== 1'b0) begin failures++; $display("FAIL sat_fill%0d: got %b expected 0", k, stall); end
      tick();
    end
    drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL sat_full: got %b expected 1", stall); end
    tick();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7);
    tick();
    drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL sat_after_retire: got %b expected 0", stall); end
    tick();
    drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL sat_refull: got %b expected 1", stall); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7);
      tick();
      checks++;
      if (busy !== ((k < 2) ? 32'h0000_0080 : 32'h0)) begin
        failures++; $display("FAIL sat_drain%0d: got %h expected %h", k, busy, (k < 2) ? 32'h0000_0080 : 32'h0);
      end
    end
    idle();
    checks++;
    if (underflow_err !== 1'b0) begin failures++; $display("FAIL sat_uf: got %b expected 0", underflow_err); end
  endtask

  task automatic test_same_cycle();
    drive(1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL same_stall: got %b expected 0", stall); end
    tick();
    checks++;
    if (busy !== 32'h0000_0200) begin failures++; $display("FAIL same_busy: got %h expected 00000200", busy); end
    drive(1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 1'b1, 5'd9);
    tick();
    idle();
    checks++;
    if (busy !== 32'h0000_0040) begin failures++; $display("FAIL diff_busy: got %h expected 00000040", busy); end
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd6);
    tick();
    idle();
    checks++;
    if ({underflow_err, busy} !== 33'h0) begin failures++; $display("FAIL same_drain: got %h expected 0", {underflow_err, busy}); end
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd12);
    tick();
    idle();
    checks++;
    if (underflow_err !== 1'b1) begin failures++; $display("FAIL uf_set: got %b expected 1", underflow_err); end
    tick();
    checks++;
    if (underflow_err !== 1'b1) begin failures++; $display("FAIL uf_sticky: got %b expected 1", underflow_err); end
    drive(1'b1, 1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
    tick();
    checks++;
    if (busy !== 32'h0000_0006) begin failures++; $display("FAIL uf_prefill: got %h expected 00000006", busy); end
    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 5'd1);
    tick();
    reset = 1'b0;
    idle();
    checks++;
    if ({underflow_err, busy} !== 33'h0) begin failures++; $display("FAIL midrun_reset: got %h expected 0", {underflow_err, busy}); end
    drive(1'b1, 1'b1, 5'd13, 5'd0, 5'd0, 1'b0, 1'b1, 5'd13);
    tick();
    idle();
    checks++;
    if ({underflow_err, busy} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL uf_issue_retire: got %h expected %h", {underflow_err, busy}, {1'b1, 32'h0});
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_issue();
    test_raw();
    test_x31();
    test_saturate();
    test_same_cycle();
    test_underflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
